// File: rtl/wb_mem_responder.sv
// Wishbone-style word RAM responder with byte-lane writes,
// programmable wait states and error response for unmapped addresses.
module wb_mem_responder #(
    parameter int          MEM_WORDS   = 4096,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 1,
    parameter string       MEMORY_FILE = ""
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic        we_i,
    input  logic [3:0]  wstrb_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        ack_o,
    output logic        err_o
);

    localparam int          AW        = $clog2(MEM_WORDS);
    localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) * 33'd4;
    localparam logic [3:0]  CNT_INIT  =
        (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    logic [31:0] mem [MEM_WORDS];

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [3:0]      wstrb_q, wstrb_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            inr_q, inr_d;
    logic            ack_q, ack_d;
    logic            err_q, err_d;
    logic [31:0]     data_q, data_d;

    logic [31:0]     offset;
    logic            in_range;
    logic [31:0]     rdata;
    logic            mem_we;
    logic            unused_bits;

    assign offset      = addr_i - ADDR_BASE;
    assign in_range    = {1'b0, offset} < MEM_BYTES;
    assign rdata       = mem[idx_q];
    assign mem_we      = (state_q == S_RESP) && inr_q && we_q;
    assign unused_bits = ^{offset[1:0], offset[31:AW+2]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        wstrb_d = wstrb_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        inr_d   = inr_q;
        data_d  = data_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (cyc_i && stb_i) begin
                    we_d    = we_i;
                    wstrb_d = wstrb_i;
                    idx_d   = offset[AW+1:2];
                    wdata_d = data_i;
                    inr_d   = in_range;
                    if (WAIT_CYCLES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = S_RESP;
                    end
                end
            end
            S_WAIT: begin
                if (!cyc_i) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                if (inr_q) begin
                    ack_d = 1'b1;
                    if (!we_q) data_d = rdata;
                end else begin
                    err_d  = 1'b1;
                    data_d = 32'h0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            wstrb_q <= 4'h0;
            idx_q   <= '0;
            wdata_q <= 32'h0;
            inr_q   <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            wstrb_q <= wstrb_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            inr_q   <= inr_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            data_q  <= data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
    end

    assign data_o = data_q;
    assign ack_o  = ack_q;
    assign err_o  = err_q;

endmodule

// File: tb/tb_wb_mem_responder.sv
// Bench for wb_mem_responder: three instances with different
// wait states / address maps, table vectors plus a response scoreboard.
module tb_wb_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n [3];
    logic        cyc   [3];
    logic        stb   [3];
    logic        we    [3];
    logic [3:0]  strb  [3];
    logic [31:0] addr  [3];
    logic [31:0] wd    [3];
    logic [31:0] rd    [3];
    logic        ack   [3];
    logic        err   [3];

    wb_mem_responder #(
        .MEM_WORDS(4096), .ADDR_BASE(32'h0), .WAIT_CYCLES(1)
    ) u0 (
        .clk(clk), .rst_n(rst_n[0]), .cyc_i(cyc[0]), .stb_i(stb[0]),
        .we_i(we[0]), .wstrb_i(strb[0]), .addr_i(addr[0]),
        .data_i(wd[0]), .data_o(rd[0]), .ack_o(ack[0]), .err_o(err[0])
    );

    wb_mem_responder #(
        .MEM_WORDS(1024), .ADDR_BASE(32'h8000_0000), .WAIT_CYCLES(0)
    ) u1 (
        .clk(clk), .rst_n(rst_n[1]), .cyc_i(cyc[1]), .stb_i(stb[1]),
        .we_i(we[1]), .wstrb_i(strb[1]), .addr_i(addr[1]),
        .data_i(wd[1]), .data_o(rd[1]), .ack_o(ack[1]), .err_o(err[1])
    );

    wb_mem_responder #(
        .MEM_WORDS(4096), .ADDR_BASE(32'h0), .WAIT_CYCLES(3)
    ) u2 (
        .clk(clk), .rst_n(rst_n[2]), .cyc_i(cyc[2]), .stb_i(stb[2]),
        .we_i(we[2]), .wstrb_i(strb[2]), .addr_i(addr[2]),
        .data_i(wd[2]), .data_o(rd[2]), .ack_o(ack[2]), .err_o(err[2])
    );

    typedef struct {
        logic        err;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    typedef struct {
        int          inst;
        logic        we;
        logic [3:0]  strb;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        eerr;
        logic [31:0] edata;
    } vec_t;

    exp_t sbq [3][$];
    vec_t vt [$];
    int   wl [3] = '{1, 0, 3};
    int   pulses [3] = '{0, 0, 0};
    int   cycnt = 0;
    int   nchk = 0;
    int   nerr = 0;

    always @(posedge clk) cycnt++;

    // Scoreboard: every ack/err pulse must match the oldest expectation.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst_n[i] && (ack[i] || err[i])) begin
                exp_t e;
                pulses[i]++;
                nchk++;
                if (ack[i] && err[i]) begin
                    nerr++;
                    $display("FAIL ack_err_both inst%0d at cycle %0d", i, cycnt);
                end else if (sbq[i].size() == 0) begin
                    nerr++;
                    $display("FAIL unexpected_pulse inst%0d: ack=%0b err=%0b cycle=%0d, want none",
                             i, ack[i], err[i], cycnt);
                end else begin
                    e = sbq[i].pop_front();
                    if (err[i] !== e.err || rd[i] !== e.data || cycnt != e.cyc) begin
                        nerr++;
                        $display("FAIL resp inst%0d: got err=%0b data=%h cycle=%0d, want err=%0b data=%h cycle=%0d",
                                 i, err[i], rd[i], cycnt, e.err, e.data, e.cyc);
                    end
                end
            end
        end
    end

    function automatic void add(int i, logic w, logic [3:0] s, logic [31:0] a,
                                logic [31:0] d, logic ee, logic [31:0] ed);
        vec_t v;
        v.inst = i; v.we = w; v.strb = s; v.addr = a;
        v.wd = d; v.eerr = ee; v.edata = ed;
        vt.push_back(v);
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] want);
        nchk++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic txn(vec_t v);
        int   i;
        bit   got;
        exp_t e;
        i = v.inst;
        got = 1'b0;
        @(posedge clk);
        #1;
        cyc[i] = 1'b1; stb[i] = 1'b1; we[i] = v.we;
        strb[i] = v.strb; addr[i] = v.addr; wd[i] = v.wd;
        e.err = v.eerr; e.data = v.edata; e.cyc = cycnt + 2 + wl[i];
        sbq[i].push_back(e);
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (ack[i] || err[i]) begin
                got = 1'b1;
                break;
            end
        end
        #1;
        cyc[i] = 1'b0; stb[i] = 1'b0;
        if (!got) begin
            nchk++;
            nerr++;
            $display("FAIL timeout inst%0d addr %h: no response, want one", i, v.addr);
            sbq[i].delete();
        end
    endtask

    initial begin
        int   p0;
        int   c0;
        bit   got;
        exp_t e;
        logic [31:0] baddr [4] = '{32'h8000_0000, 32'h8000_0004,
                                   32'h8000_0008, 32'h8000_000C};
        logic [31:0] bdata [4] = '{32'h0102_0304, 32'h0A0B_0C0D,
                                   32'h1020_3040, 32'h5566_7788};

        for (int i = 0; i < 3; i++) begin
            rst_n[i] = 1'b0; cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0;
            strb[i] = 4'h0; addr[i] = 32'h0; wd[i] = 32'h0;
        end

        // u0: 4096 words at 0, one wait state
        add(0, 1, 4'hF, 32'h0000_0000, 32'hDEAD_BEEF, 0, 32'h0);
        add(0, 0, 4'h0, 32'h0000_0000, 32'h0,         0, 32'hDEAD_BEEF);
        add(0, 1, 4'hF, 32'h0000_0010, 32'h1122_3344, 0, 32'hDEAD_BEEF);
        add(0, 1, 4'h5, 32'h0000_0010, 32'hAABB_CCDD, 0, 32'hDEAD_BEEF);
        add(0, 0, 4'h0, 32'h0000_0010, 32'h0,         0, 32'h11BB_33DD);
        add(0, 1, 4'h0, 32'h0000_0010, 32'hFFFF_FFFF, 0, 32'h11BB_33DD);
        add(0, 0, 4'h0, 32'h0000_0010, 32'h0,         0, 32'h11BB_33DD);
        add(0, 1, 4'hF, 32'h0000_3FFC, 32'h1234_5678, 0, 32'h11BB_33DD);
        add(0, 0, 4'h0, 32'h0000_3FFC, 32'h0,         0, 32'h1234_5678);
        add(0, 0, 4'h0, 32'h0000_4000, 32'h0,         1, 32'h0);
        add(0, 0, 4'h0, 32'h0000_0013, 32'h0,         0, 32'h11BB_33DD);
        add(0, 1, 4'hF, 32'h0000_4000, 32'h7777_7777, 1, 32'h0);
        add(0, 0, 4'h0, 32'h0000_0000, 32'h0,         0, 32'hDEAD_BEEF);
        // u1: 1024 words at 0x8000_0000, no wait states
        add(1, 1, 4'hF, 32'h8000_0FFC, 32'hCAFE_F00D, 0, 32'h0);
        add(1, 0, 4'h0, 32'h8000_0FFC, 32'h0,         0, 32'hCAFE_F00D);
        add(1, 0, 4'h0, 32'h8000_1000, 32'h0,         1, 32'h0);
        add(1, 0, 4'h0, 32'h7FFF_FFFC, 32'h0,         1, 32'h0);
        for (int j = 0; j < 4; j++) add(1, 1, 4'hF, baddr[j], bdata[j], 0, 32'h0);
        // u2: three wait states
        add(2, 1, 4'hF, 32'h0000_0020, 32'h0000_00AA, 0, 32'h0);
        add(2, 0, 4'h0, 32'h0000_0020, 32'h0,         0, 32'h0000_00AA);
        add(2, 1, 4'hF, 32'h0000_0024, 32'h0000_0077, 0, 32'h0000_00AA);
        add(2, 1, 4'hF, 32'h0000_0040, 32'h0000_1234, 0, 32'h0000_00AA);
        add(2, 0, 4'h0, 32'h0000_0024, 32'h0,         0, 32'h0000_0077);

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset_ack%0d", i), 32'(ack[i]), 32'h0);
            check($sformatf("reset_err%0d", i), 32'(err[i]), 32'h0);
            check($sformatf("reset_data%0d", i), rd[i], 32'h0);
            rst_n[i] = 1'b1;
        end

        foreach (vt[k]) txn(vt[k]);

        // u1: request held across acks, one accept every second cycle
        @(posedge clk);
        #1;
        c0 = cycnt;
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; addr[1] = baddr[0];
        for (int j = 0; j < 4; j++) begin
            e.err = 1'b0; e.data = bdata[j]; e.cyc = c0 + 2 + 2 * j;
            sbq[1].push_back(e);
        end
        p0 = pulses[1];
        for (int j = 0; j < 4; j++) begin
            got = 1'b0;
            for (int n = 0; n < 10; n++) begin
                @(negedge clk);
                if (ack[1] || err[1]) begin
                    got = 1'b1;
                    break;
                end
            end
            #1;
            if (j < 3) addr[1] = baddr[j + 1];
            if (!got) break;
        end
        cyc[1] = 1'b0; stb[1] = 1'b0;
        repeat (3) @(posedge clk);
        check("burst_ack_count", 32'(pulses[1] - p0), 32'd4);

        // u2: cyc drops during wait states, write must be abandoned
        @(posedge clk);
        #1;
        cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1;
        strb[2] = 4'hF; addr[2] = 32'h20; wd[2] = 32'h5;
        p0 = pulses[2];
        repeat (2) @(posedge clk);
        #1;
        cyc[2] = 1'b0; stb[2] = 1'b0;
        repeat (8) @(posedge clk);
        check("abort_no_pulse", 32'(pulses[2] - p0), 32'd0);
        txn('{2, 1'b0, 4'h0, 32'h20, 32'h0, 1'b0, 32'h0000_00AA});

        // u2: reset in the middle of a write's wait states
        txn('{2, 1'b0, 4'h0, 32'h40, 32'h0, 1'b0, 32'h0000_1234});
        @(posedge clk);
        #1;
        cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1;
        strb[2] = 4'hF; addr[2] = 32'h40; wd[2] = 32'hFFFF_0000;
        repeat (2) @(posedge clk);
        #2;
        rst_n[2] = 1'b0;
        #1;
        check("rst_async_ack", 32'(ack[2]), 32'h0);
        check("rst_async_err", 32'(err[2]), 32'h0);
        check("rst_async_data", rd[2], 32'h0);
        cyc[2] = 1'b0; stb[2] = 1'b0;
        @(posedge clk);
        #1;
        rst_n[2] = 1'b1;
        txn('{2, 1'b0, 4'h0, 32'h40, 32'h0, 1'b0, 32'h0000_1234});

        repeat (4) @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("sb_drained%0d", i), 32'(sbq[i].size()), 32'h0);
        end
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
